crc_stream_engine: RTL and testbench

Parametrised streaming CRC engine, the successor to the serial CRC-16/ANSI block. It absorbs DATA_W bits per cycle under a valid/ready handshake with frame delimiters. Polynomial, width, init, reflection and final XOR are all configurable. It produces a registered CRC and a residue-check flag per frame, and sits between a byte/bit source and the framing/checking logic.

---
 rtl/crc_stream_pkg.sv | 16 +
 rtl/crc_stream_engine_step.sv | 23 ++
 rtl/crc_stream_engine.sv | 66 ++++++
 tb/tb_crc_stream_engine.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/crc_stream_pkg.sv
// crc_stream_pkg: FSM state type plus bit-reverse and single-bit LFSR helpers for the streaming CRC engine
package crc_stream_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // Reverses the low n bits of v; bits at and above n are dropped.
  function automatic logic [31:0] rev(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = {<<{v}};
    return r >> (32 - n);
  endfunction
  // One MSB-first LFSR update of a w-bit register; result is masked to w bits.
  function automatic logic [31:0] crc_bit_step(input logic [31:0] r, input logic b, input logic [31:0] poly, input int w);
    logic fb;
    fb = b ^ (|(r & (32'h1 << (w - 1))));
    return ((r << 1) ^ (fb ? poly : 32'h0)) & ((32'h1 << w) - 32'h1);
  endfunction
endpackage

// File: rtl/crc_stream_engine_step.sv
// crc_stream_step: combinational DATA_W-bit unrolled CRC update
// ports: i_crc current register, i_data beat, o_crc register after absorbing the beat
module crc_stream_step
  import crc_stream_pkg::*;
#(
  parameter int          CRC_W  = 16,
  parameter logic [31:0] POLY   = 32'h8005,
  parameter int          DATA_W = 8,
  parameter logic        REFIN  = 1'b1
) (
  input  logic [CRC_W-1:0]  i_crc,
  input  logic [DATA_W-1:0] i_data,
  output logic [CRC_W-1:0]  o_crc
);
  logic [DATA_W-1:0] w_d;
  logic [CRC_W-1:0]  w_r;
  always_comb begin
    w_d = REFIN ? DATA_W'(rev(32'(i_data), DATA_W)) : i_data;
    w_r = i_crc;
    for (int k = DATA_W - 1; k >= 0; k--) w_r = CRC_W'(crc_bit_step(32'(w_r), w_d[k], POLY, CRC_W));
    o_crc = w_r;
  end
endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming CRC with valid/ready beats, sop/eop framing and a residue-match flag
// ports: clk_i/rst_n_i clock and sync active-low reset; data_i/valid_i/sop_i/eop_i/ready_o beat handshake;
//        crc_o/match_o/crc_valid_o frame result; err_o protocol-violation pulse
module crc_stream_engine
  import crc_stream_pkg::*;
#(
  parameter int          CRC_W   = 16,
  parameter logic [31:0] POLY    = 32'h8005,
  parameter logic [31:0] INIT    = 32'h0000,
  parameter logic [31:0] XOR_OUT = 32'h0000,
  parameter logic        REFIN   = 1'b1,
  parameter logic        REFOUT  = 1'b1,
  parameter logic [31:0] RESIDUE = 32'h0000,
  parameter int          DATA_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              sop_i,
  input  logic              eop_i,
  output logic              ready_o,
  output logic [CRC_W-1:0]  crc_o,
  output logic              crc_valid_o,
  output logic              match_o,
  output logic              err_o
);
  state_t            r_state, w_nxt;
  logic [CRC_W-1:0]  r_reg, r_crc, w_base, w_step;
  logic              r_match, r_err, w_acc, w_load, w_err;
  // A beat is absorbed when it starts a frame (from IDLE or as an abort in RUN) or continues one.
  assign w_acc  = valid_i && ready_o;
  assign w_load = w_acc && (sop_i || r_state == RUN);
  assign w_err  = w_acc && (r_state == IDLE ? !sop_i : (r_state == RUN && sop_i));
  assign w_base = sop_i ? INIT[CRC_W-1:0] : r_reg;
  crc_stream_step #(.CRC_W(CRC_W), .POLY(POLY), .DATA_W(DATA_W), .REFIN(REFIN)) u_step (
    .i_crc (w_base),
    .i_data(data_i),
    .o_crc (w_step)
  );
  always_ff @(posedge clk_i) r_state <= !rst_n_i ? IDLE : w_nxt;
  always_comb w_nxt = r_state == DONE ? IDLE : w_load ? (eop_i ? DONE : RUN) : r_state;
  // Results are captured on the edge that enters DONE so they line up with crc_valid_o.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_reg   <= INIT[CRC_W-1:0];
      r_crc   <= '0;
      r_match <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_load) r_reg <= w_step;
      if (w_load && eop_i) begin
        r_crc   <= CRC_W'((REFOUT ? rev(32'(w_step), CRC_W) : 32'(w_step)) ^ XOR_OUT);
        r_match <= w_step == RESIDUE[CRC_W-1:0];
      end
    end
  end
  always_comb begin
    ready_o     = r_state != DONE;
    crc_valid_o = r_state == DONE;
    crc_o       = r_crc;
    match_o     = r_match;
    err_o       = r_err;
  end
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: random and known-vector frames against a byte-wise CRC reference model
module tb_crc_stream_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, valid, sop, eop;
  logic [7:0] data;
  logic ra, rm, rx, va, vm, vx, ma, mm, mx, ea, em, ex;
  logic [15:0] ca, cm, cx, cb;
  logic b_data, b_valid, b_sop, b_eop, rb, vb, mb, eb;
  int n_chk = 0, n_fail = 0, n_va = 0;
  logic [7:0] std_q[$], q[$];
  crc_stream_engine u_arc (.clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .sop_i(sop), .eop_i(eop),
    .ready_o(ra), .crc_o(ca), .crc_valid_o(va), .match_o(ma), .err_o(ea));
  crc_stream_engine #(.INIT(32'hFFFF)) u_mod (.clk_i(clk), .rst_n_i(rst_n), .data_i(data), .valid_i(valid), .sop_i(sop),
    .eop_i(eop), .ready_o(rm), .crc_o(cm), .crc_valid_o(vm), .match_o(mm), .err_o(em));
  crc_stream_engine #(.POLY(32'h1021), .REFIN(1'b0), .REFOUT(1'b0)) u_xm (.clk_i(clk), .rst_n_i(rst_n), .data_i(data),
    .valid_i(valid), .sop_i(sop), .eop_i(eop), .ready_o(rx), .crc_o(cx), .crc_valid_o(vx), .match_o(mx), .err_o(ex));
  crc_stream_engine #(.DATA_W(1)) u_bit (.clk_i(clk), .rst_n_i(rst_n), .data_i(b_data), .valid_i(b_valid), .sop_i(b_sop),
    .eop_i(b_eop), .ready_o(rb), .crc_o(cb), .crc_valid_o(vb), .match_o(mb), .err_o(eb));
  always @(negedge clk) if (va) n_va++;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    r = {<<{x}};
    return r;
  endfunction
  // Returns the engine register in its MSB-first orientation; reflected CRCs use the
  // classic right-shifting algorithm with the reversed polynomial.
  function automatic logic [15:0] model_reg(input logic [7:0] m[$], input logic [15:0] poly, input logic [15:0] init, input logic refin);
    logic [15:0] c;
    c = refin ? rev16(init) : init;
    foreach (m[i]) begin
      c = refin ? c ^ {8'h00, m[i]} : c ^ {m[i], 8'h00};
      for (int j = 0; j < 8; j++)
        c = refin ? (c[0] ? (c >> 1) ^ rev16(poly) : c >> 1) : (c[15] ? (c << 1) ^ poly : c << 1);
    end
    return refin ? rev16(c) : c;
  endfunction
  task automatic send_beat(input logic [7:0] d, input logic s, input logic e, input int gap);
    valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    data = d; sop = s; eop = e; valid = 1'b1;
    for (int t = 0; t < 8 && !ra; t++) begin @(posedge clk); #1; end
    if (!ra) check("ready_wait", 16'(ra), 16'h1);
    @(posedge clk); #1;
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] m[$], input int gmax);
    foreach (m[i]) send_beat(m[i], i == 0, i == m.size() - 1, $urandom_range(0, gmax));
  endtask
  task automatic check_frame(input logic [7:0] m[$]);
    logic [15:0] r_a, r_m, r_x;
    r_a = model_reg(m, 16'h8005, 16'h0000, 1'b1);
    r_m = model_reg(m, 16'h8005, 16'hFFFF, 1'b1);
    r_x = model_reg(m, 16'h1021, 16'h0000, 1'b0);
    @(negedge clk);
    check("valid_pulse", 16'({va, vm, vx}), 16'h7);
    check("arc_crc", ca, rev16(r_a));
    check("mod_crc", cm, rev16(r_m));
    check("xm_crc", cx, r_x);
    check("arc_match", 16'(ma), 16'(r_a == 16'h0));
    check("mod_match", 16'(mm), 16'(r_m == 16'h0));
    check("xm_match", 16'(mx), 16'(r_x == 16'h0));
    check("done_ready", 16'(ra), 16'h0);
    @(negedge clk);
    check("valid_end", 16'({va, vm, vx}), 16'h0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int n_before;
    rst_n = 1'b0; data = '0; valid = 1'b0; sop = 1'b0; eop = 1'b0;
    b_data = 1'b0; b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
    for (int i = 0; i < 9; i++) std_q.push_back(8'(8'h31 + i));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_crc", ca, 16'h0);
    check("rst_valid", 16'(va), 16'h0);
    check("rst_err", 16'(ea), 16'h0);
    check("rst_match", 16'(ma), 16'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 16'(ra), 16'h1);
    send_frame(std_q, 0);
    check_frame(std_q);
    check("arc_vec", ca, 16'hBB3D);
    check("mod_vec", cm, 16'h4B37);
    check("xm_vec", cx, 16'h31C3);
    check("arc_nomatch", 16'(ma), 16'h0);
    q = std_q; q.push_back(8'h3D); q.push_back(8'hBB);
    send_frame(q, 1);
    check_frame(q);
    check("arc_residue", 16'(ma), 16'h1);
    repeat (20) begin
      q = {};
      repeat ($urandom_range(1, 12)) q.push_back(8'($urandom));
      send_frame(q, 2);
      check_frame(q);
    end
    send_beat(8'h55, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("idle_err", 16'(ea), 16'h1);
    check("idle_novalid", 16'(va), 16'h0);
    send_beat(8'h66, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("idle_err_eop", 16'(ea), 16'h1);
    @(negedge clk);
    check("idle_err_end", 16'(ea), 16'h0);
    check("idle_eop_novalid", 16'(va), 16'h0);
    for (int i = 0; i < 3; i++) send_beat(std_q[i], i == 0, 1'b0, 0);
    check("no_err_run", 16'(ea), 16'h0);
    send_beat(std_q[0], 1'b1, 1'b0, 0);
    @(negedge clk);
    check("abort_err", 16'(ea), 16'h1);
    for (int i = 1; i < 9; i++) send_beat(std_q[i], 1'b0, i == 8, 0);
    check_frame(std_q);
    check("abort_vec", ca, 16'hBB3D);
    n_before = n_va;
    for (int i = 0; i < 4; i++) send_beat(std_q[i], i == 0, 1'b0, 0);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_crc", ca, 16'h0);
    check("mid_rst_mod_crc", cm, 16'h0);
    check("mid_rst_match", 16'(ma), 16'h0);
    check("mid_rst_err", 16'(ea), 16'h0);
    check("mid_rst_ready", 16'(ra), 16'h1);
    repeat (4) @(negedge clk);
    check("mid_rst_novalid", 16'(n_va), 16'(n_before));
    send_frame(std_q, 0);
    check_frame(std_q);
    check("post_rst_vec", ca, 16'hBB3D);
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < 8; k++) begin
        b_data = std_q[i][k]; b_sop = i == 0 && k == 0; b_eop = i == 8 && k == 7; b_valid = 1'b1;
        @(posedge clk); #1;
      end
    b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
    @(negedge clk);
    check("bit_valid", 16'(vb), 16'h1);
    check("bit_crc", cb, 16'hBB3D);
    @(negedge clk);
    check("bit_valid_end", 16'(vb), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
